// File: rtl/wave_frame_store.sv
// Double-buffered capture store feeding a waveform overlay; swaps banks only in vertical blank.
// Optional WAVE_SEGMENT_EN joins consecutive samples with vertical segments instead of dots.
module wave_frame_store #(
    parameter int N_SAMPLES   = 512,
    parameter int DW          = 12,
    parameter int X_LEFT      = 144,
    parameter int Y_TOP       = 44,
    parameter int Y_SHIFT     = 3,
    parameter int V_SWAP_LINE = 601
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          wr_clear,
    input  logic [10:0]   hcount,
    input  logic [10:0]   vcount,
    output logic          trace_on,
    output logic          frame_swapped,
    output logic          capture_pending
);
    localparam int AW = $clog2(N_SAMPLES);

    typedef enum logic [1:0] {FILL, FULL, SWAP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          bank_sel_q;
    logic          disp_valid_q;
    logic          we;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        we        = 1'b0;
        case (state_q)
            FILL: begin
                if (wr_clear) begin
                    wr_addr_d = '0;
                end else if (wr_valid) begin
                    we = 1'b1;
                    if (wr_addr_q == AW'(N_SAMPLES - 1)) begin
                        wr_addr_d = '0;
                        state_d   = FULL;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            FULL: begin
                // Abandoning the capture takes priority over a swap in the same cycle.
                if (wr_clear)
                    state_d = FILL;
                else if (vcount == 11'(V_SWAP_LINE) && hcount == '0)
                    state_d = SWAP;
            end
            SWAP:    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            wr_addr_q    <= '0;
            bank_sel_q   <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            if (state_q == SWAP) begin
                bank_sel_q   <= ~bank_sel_q;
                disp_valid_q <= 1'b1;
            end
        end
    end

    assign wr_ready        = (state_q == FILL);
    assign capture_pending = (state_q == FULL);
    assign frame_swapped   = (state_q == SWAP);

    // Both banks share one array; the top address bit is the bank.
    logic [DW-1:0] mem [2*N_SAMPLES];
    logic [DW-1:0] rd_q;
    logic [AW-1:0] rd_addr;
    logic          in_x;

    assign in_x    = (hcount >= 11'(X_LEFT)) && (hcount < 11'(X_LEFT + N_SAMPLES));
    assign rd_addr = AW'(hcount - 11'(X_LEFT));

    always_ff @(posedge clk) begin
        if (we)
            mem[{~bank_sel_q, wr_addr_q}] <= wr_data;
        rd_q <= mem[{bank_sel_q, rd_addr}];
    end

    logic          in_x1_q;
    logic [10:0]   v1_q;
    logic [DW-1:0] inv;
    logic [10:0]   y_cur;
    logic          hit;
    logic          trace_q;

    // ~q == full-scale - q for unsigned samples, so high codes land near the top.
    assign inv   = ~rd_q;
    assign y_cur = 11'(Y_TOP) + 11'(inv >> Y_SHIFT);

`ifdef WAVE_SEGMENT_EN
    logic        in_x2_q;
    logic [10:0] y_prev_q;
    logic [10:0] y_prv, y_lo, y_hi;

    // First column of a line has no predecessor: draw it as a point.
    assign y_prv = in_x2_q ? y_prev_q : y_cur;
    assign y_lo  = (y_prv < y_cur) ? y_prv : y_cur;
    assign y_hi  = (y_prv < y_cur) ? y_cur : y_prv;
    assign hit   = (v1_q >= y_lo) && (v1_q <= y_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_x2_q  <= 1'b0;
            y_prev_q <= '0;
        end else begin
            in_x2_q <= in_x1_q;
            if (in_x1_q)
                y_prev_q <= y_cur;
        end
    end
`else
    assign hit = (v1_q == y_cur);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            in_x1_q <= 1'b0;
            v1_q    <= '0;
            trace_q <= 1'b0;
        end else begin
            in_x1_q <= in_x;
            v1_q    <= vcount;
            trace_q <= in_x1_q && disp_valid_q && hit;
        end
    end

    assign trace_on = trace_q;
endmodule

// File: tb/tb_wave_frame_store.sv
// Directed bench for wave_frame_store: pixel-level reference of the displayed trace
// plus literal per-line hit counts and handshake/status checks.
module tb_wave_frame_store;
    localparam int N = 512;
`ifdef WAVE_SEGMENT_EN
    localparam bit SEG = 1'b1;
`else
    localparam bit SEG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        wr_clear;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        trace_on;
    logic        frame_swapped;
    logic        capture_pending;

    wave_frame_store dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_clear(wr_clear),
        .hcount(hcount), .vcount(vcount),
        .trace_on(trace_on), .frame_swapped(frame_swapped), .capture_pending(capture_pending)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int disp[N];
    int pend[N];
    int pcnt = 0;
    bit m_full = 0, m_valid = 0;
    int swaps_seen = 0, exp_swaps = 0;
    int hits = 0;
    bit exp_d1 = 0, exp_d2 = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int yof(input int s);
        return 44 + ((4095 - s) >> 3);
    endfunction

    // Is screen pixel (h,v) on the currently displayed capture?
    function automatic bit model_px(input int h, input int v);
        int i, yc, yp, lo, hi;
        if (!m_valid || h < 144 || h >= 144 + N) return 1'b0;
        i  = h - 144;
        yc = yof(disp[i]);
        yp = (SEG && i > 0) ? yof(disp[i-1]) : yc;
        lo = (yp < yc) ? yp : yc;
        hi = (yp < yc) ? yc : yp;
        return (v >= lo) && (v <= hi);
    endfunction

    always @(posedge clk) begin
        exp_d1 <= model_px(int'(hcount), int'(vcount));
        exp_d2 <= exp_d1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("trace_on", int'(trace_on), int'(exp_d2));
            if (trace_on) hits++;
            if (frame_swapped) swaps_seen++;
        end
    end

    task automatic cyc(input int h, input int v, input bit val = 0, input int d = 0, input bit clr = 0);
        hcount   = 11'(h);
        vcount   = 11'(v);
        wr_valid = val;
        wr_data  = 12'(d);
        wr_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int v = 0);
        if (!m_full) begin
            pend[pcnt] = d;
            pcnt++;
            if (pcnt == N) begin
                m_full = 1;
                pcnt   = 0;
            end
        end
        cyc(0, v, 1'b1, d, 1'b0);
    endtask

    task automatic clear(input bit val);
        if (m_full) m_full = 0;
        else        pcnt   = 0;
        cyc(0, 0, val, 777, 1'b1);
    endtask

    task automatic swap_px();
        if (m_full) begin
            disp      = pend;
            m_valid   = 1;
            m_full    = 0;
            exp_swaps++;
        end
        cyc(0, 601);
        cyc(0, 602);
        cyc(0, 602);
        chk("frame_swapped_count", swaps_seen, exp_swaps);
    endtask

    task automatic scan(input int v, input int exp_hits);
        hits = 0;
        for (int h = 140; h <= 660; h++) cyc(h, v);
        for (int k = 0; k < 3; k++) cyc(0, v);
        chk($sformatf("hits_row%0d", v), hits, exp_hits);
    endtask

    initial begin
        rst = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        rst = 1'b0;
        cyc(0, 0);
        cmp_en = 1;
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_pending", int'(capture_pending), 0);
        chk("rst_swapped", int'(frame_swapped), 0);
        chk("rst_trace_on", int'(trace_on), 0);

        // Idle frame: nothing displayed, no swap.
        scan(44, 0);
        scan(299, 0);
        swap_px();
        chk("idle_wr_ready", int'(wr_ready), 1);
        chk("idle_pending", int'(capture_pending), 0);

        // Flat mid-scale capture.
        for (int i = 0; i < N; i++) begin
            push(2048);
            if (i == N - 2) chk("ready_before_last", int'(wr_ready), 1);
        end
        chk("full_wr_ready", int'(wr_ready), 0);
        chk("full_pending", int'(capture_pending), 1);
        push(100);
        chk("full_ignore_pending", int'(capture_pending), 1);
        swap_px();
        chk("post_swap_pending", int'(capture_pending), 0);
        chk("post_swap_ready", int'(wr_ready), 1);
        scan(298, 0);
        scan(299, 512);
        scan(300, 0);

        // Ramp: column i sits on row 555-i.
        for (int i = 0; i < N; i++) push(i * 8);
        swap_px();
        scan(555, SEG ? 2 : 1);
        scan(300, SEG ? 2 : 1);
        scan(44, 1);

        // Clear at sample 300 restarts the capture.
        for (int i = 0; i < 300; i++) push(4095 - 8 * i);
        clear(1'b1);
        for (int i = 0; i < N - 1; i++) push(4095 - 8 * i);
        chk("clear_pending_early", int'(capture_pending), 0);
        push(4095 - 8 * (N - 1));
        chk("clear_pending_done", int'(capture_pending), 1);
        swap_px();
        scan(100, SEG ? 2 : 1);

        // Second capture blocked while the first is pending.
        for (int i = 0; i < N; i++) push(1024, 400);
        chk("capA_pending", int'(capture_pending), 1);
        for (int i = 0; i < 4; i++) push(3072, 400);
        chk("capB_blocked", int'(wr_ready), 0);
        swap_px();
        scan(427, 512);
        for (int i = 0; i < N; i++) push(3072);
        chk("capB_pending", int'(capture_pending), 1);
        scan(427, 512);
        scan(171, 0);
        swap_px();
        scan(171, 512);
        scan(427, 0);

        // Clear while FULL discards the capture and keeps the display.
        for (int i = 0; i < N; i++) push(0);
        clear(1'b0);
        chk("fullclr_pending", int'(capture_pending), 0);
        chk("fullclr_ready", int'(wr_ready), 1);
        swap_px();
        scan(171, 512);
        scan(555, 0);

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
